alu_seq_unit: RTL and testbench

- Parametrised WIDTH-bit multi-cycle ALU; successor to the 1-bit ALU slice.
- Same funct-code op set (AND/OR/ADD/SUB/SLT), plus SRL and an iterative unsigned divider (DIVU).
- Single-cycle ops and the WIDTH-cycle divide share one start/busy/done handshake and registered result/remainder outputs.
- Sits between the datapath register read stage and writeback.

---
 rtl/alu_seq_unit_pkg.sv | 19 +
 rtl/alu_seq_unit_if.sv | 28 ++
 rtl/alu_seq_unit_comb_core.sv | 63 ++++++
 rtl/alu_seq_unit.sv | 144 ++++++++++++++
 tb/tb_alu_seq_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_unit_pkg.sv
// Shared definitions for the multi-cycle ALU: funct codes and FSM state encoding.
// The optional ALU_OVERFLOW_EN build only affects alu_comb_core and alu_seq_unit.
package alu_pkg;

    localparam logic [5:0] ALU_AND  = 6'd36;
    localparam logic [5:0] ALU_OR   = 6'd37;
    localparam logic [5:0] ALU_ADD  = 6'd32;
    localparam logic [5:0] ALU_SUB  = 6'd34;
    localparam logic [5:0] ALU_SRL  = 6'd2;
    localparam logic [5:0] ALU_SLT  = 6'd42;
    localparam logic [5:0] ALU_DIVU = 6'd27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between the register-read stage and the multi-cycle ALU.
interface alu_seq_unit_if #(
    parameter int WIDTH = 32
) ();
    import alu_pkg::*;

    logic             start;
    logic [5:0]       signal;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] rem;
    logic             zero;
    logic             dz;
    logic             ovf;

    modport master (
        output start, signal, a, b,
        input  busy, done, result, rem, zero, dz, ovf
    );

    modport slave (
        input  start, signal, a, b,
        output busy, done, result, rem, zero, dz, ovf
    );
endinterface

// File: rtl/alu_seq_unit_comb_core.sv
// Combinational WIDTH-bit AND/OR/ADD/SUB/SLT/SRL; unknown codes and DIVU yield 0.
// ovf_o exists only when ALU_OVERFLOW_EN is defined.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [5:0]       funct_i,
`ifdef ALU_OVERFLOW_EN
    output logic             ovf_o,
`endif
    output logic [WIDTH-1:0] result_o
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] and_v, or_v, sum_v, diff_v, srl_v;
    logic             ovf_sub, slt_v;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign and_v[gi] = a_i[gi] & b_i[gi];
            assign or_v[gi]  = a_i[gi] | b_i[gi];
        end
    endgenerate

    assign sum_v  = a_i + b_i;
    assign diff_v = a_i + ~b_i + WIDTH'(1);
    assign srl_v  = a_i >> b_i[SHW-1:0];

    // SLT needs the subtract overflow term regardless of whether ovf is exported
    assign ovf_sub = (a_i[MSB] != b_i[MSB]) && (diff_v[MSB] != a_i[MSB]);
    assign slt_v   = diff_v[MSB] ^ ovf_sub;

    always_comb begin
        result_o = '0;
        case (funct_i)
            ALU_AND: result_o = and_v;
            ALU_OR:  result_o = or_v;
            ALU_ADD: result_o = sum_v;
            ALU_SUB: result_o = diff_v;
            ALU_SRL: result_o = srl_v;
            ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, slt_v};
            default: result_o = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf_add;
    assign ovf_add = (a_i[MSB] == b_i[MSB]) && (sum_v[MSB] != a_i[MSB]);

    always_comb begin
        ovf_o = 1'b0;
        if (funct_i == ALU_ADD)
            ovf_o = ovf_add;
        else if (funct_i == ALU_SUB)
            ovf_o = ovf_sub;
    end
`endif

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: single-cycle ops via alu_comb_core plus a WIDTH-cycle restoring DIVU.
// Define ALU_OVERFLOW_EN to register signed ADD/SUB overflow on ovf; otherwise ovf is 0.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d, prem_q, prem_d, dvs_q, dvs_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d, rem_q, rem_d;
    logic             zero_q, zero_d, dz_q, dz_d;
    logic [WIDTH-1:0] core_res;
    logic [WIDTH:0]   trial, trial_diff;
    logic [WIDTH-1:0] step_quo, step_rem;

`ifdef ALU_OVERFLOW_EN
    logic ovf_q, ovf_d, core_ovf;
`endif

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (bus.a),
        .b_i      (bus.b),
        .funct_i  (bus.signal),
`ifdef ALU_OVERFLOW_EN
        .ovf_o    (core_ovf),
`endif
        .result_o (core_res)
    );

    // Partial remainder keeps its carry-out bit so divisors above 2^(WIDTH-1) stay exact
    assign trial      = {prem_q, quo_q[WIDTH-1]};
    assign trial_diff = trial - {1'b0, dvs_q};
    assign step_quo   = {quo_q[WIDTH-2:0], ~trial_diff[WIDTH]};
    assign step_rem   = trial_diff[WIDTH] ? trial[WIDTH-1:0] : trial_diff[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        quo_d    = quo_q;
        prem_d   = prem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_d    = rem_q;
        zero_d   = zero_q;
        dz_d     = dz_q;
`ifdef ALU_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef ALU_OVERFLOW_EN
                    ovf_d = core_ovf;
`endif
                    if (bus.signal == ALU_DIVU) begin
                        if (bus.b == '0) begin
                            result_d = '1;
                            rem_d    = bus.a;
                            zero_d   = 1'b0;
                            dz_d     = 1'b1;
                            state_d  = DONE;
                        end else begin
                            quo_d   = bus.a;
                            prem_d  = '0;
                            dvs_d   = bus.b;
                            cnt_d   = SHW'(WIDTH - 1);
                            state_d = DIV;
                        end
                    end else begin
                        result_d = core_res;
                        rem_d    = '0;
                        zero_d   = (core_res == '0);
                        dz_d     = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            DIV: begin
                quo_d  = step_quo;
                prem_d = step_rem;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    result_d = step_quo;
                    rem_d    = step_rem;
                    zero_d   = (step_quo == '0);
                    dz_d     = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            quo_q    <= '0;
            prem_q   <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            zero_q   <= 1'b0;
            dz_q     <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            prem_q   <= prem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            zero_q   <= zero_d;
            dz_q     <= dz_d;
`ifdef ALU_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.rem    = rem_q;
    assign bus.zero   = zero_q;
    assign bus.dz     = dz_q;
`ifdef ALU_OVERFLOW_EN
    assign bus.ovf    = ovf_q;
`else
    assign bus.ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (WIDTH=32): vector table for single-cycle ops,
// hand-written sequences for DIVU latency, ignored start, divide-by-zero and mid-divide reset.
module tb_alu_seq_unit;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef ALU_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_seq_unit_if #(.WIDTH(W)) bus ();

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.signal = op;
        bus.a      = a;
        bus.b      = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Runs one DIVU; inject>0 drives an extra ADD start during that cycle of the divide.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input int inject);
        int cyc;
        int done_cyc;
        int busy_low;
        issue(ALU_DIVU, a, b);
        bus.a = '0;
        bus.b = '0;
        cyc = 1;
        done_cyc = 0;
        busy_low = 0;
        while (done_cyc == 0 && cyc <= W + 8) begin
            if (!bus.busy) busy_low++;
            if (bus.done) begin
                done_cyc = cyc;
            end else begin
                if (cyc == inject) begin
                    bus.start  = 1'b1;
                    bus.signal = ALU_ADD;
                    bus.a      = 32'd1;
                    bus.b      = 32'd1;
                end
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                cyc++;
            end
        end
        $display("divu a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h done at T+%0d",
                 a, b, bus.result, bus.rem, done_cyc);
        check("div_done_cycle", 32'(done_cyc), 32'(W + 1));
        check("div_busy_held", 32'(busy_low), 32'd0);
        check("div_quotient", bus.result, eq);
        check("div_remainder", bus.rem, er);
        check("div_zero", {31'd0, bus.zero}, {31'd0, (eq == 32'd0)});
        check("div_dz", {31'd0, bus.dz}, 32'd0);
        check("div_ovf", {31'd0, bus.ovf}, 32'd0);
        @(posedge clk);
        #1;
        check("div_done_pulse_end", {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.signal = '0;
        bus.a      = '0;
        bus.b      = '0;
        rst_n      = 1'b0;

        vecs[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[1]  = '{ALU_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        vecs[3]  = '{ALU_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{ALU_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0};
        vecs[5]  = '{ALU_SRL, 32'h80000000, 32'h0000003F, 32'h00000001, 1'b0, 1'b0};
        vecs[6]  = '{ALU_OR,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[7]  = '{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[8]  = '{ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
        vecs[9]  = '{ALU_SRL, 32'hF0000000, 32'hFFFFFF24, 32'h0F000000, 1'b0, 1'b0};
        vecs[10] = '{6'd63,   32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0};
        vecs[11] = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {25'd0, bus.busy, bus.done, bus.zero, bus.dz, bus.ovf, 2'b00}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_rem", bus.rem, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            $display("op=%0d a=0x%08h b=0x%08h -> result=0x%08h zero=%0b ovf=%0b",
                     vecs[i].op, vecs[i].a, vecs[i].b, bus.result, bus.zero, bus.ovf);
            check($sformatf("v%0d_done_busy", i), {30'd0, bus.done, bus.busy}, 32'd3);
            check($sformatf("v%0d_result", i), bus.result, vecs[i].res);
            check($sformatf("v%0d_rem", i), bus.rem, 32'd0);
            check($sformatf("v%0d_zero", i), {31'd0, bus.zero}, {31'd0, vecs[i].z});
            check($sformatf("v%0d_dz", i), {31'd0, bus.dz}, 32'd0);
            check($sformatf("v%0d_ovf", i), {31'd0, bus.ovf}, {31'd0, vecs[i].ovf & OVF_EN});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_idle", i), {30'd0, bus.done, bus.busy}, 32'd0);
            check($sformatf("v%0d_hold", i), bus.result, vecs[i].res);
        end

        run_div(32'd100, 32'd7, 32'd14, 32'd2, 5);
        run_div(32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 0);

        issue(ALU_DIVU, 32'h12345678, 32'h00000000);
        $display("divu by zero -> result=0x%08h rem=0x%08h dz=%0b", bus.result, bus.rem, bus.dz);
        check("dz_done_t1", {31'd0, bus.done}, 32'd1);
        check("dz_result", bus.result, 32'hFFFFFFFF);
        check("dz_rem", bus.rem, 32'h12345678);
        check("dz_flag", {30'd0, bus.dz, bus.zero}, 32'd2);
        @(posedge clk);
        #1;
        issue(ALU_ADD, 32'd1, 32'd1);
        $display("add 1+1 after dz -> result=0x%08h dz=%0b", bus.result, bus.dz);
        check("post_dz_add_result", bus.result, 32'd2);
        check("post_dz_add_flags", {29'd0, bus.dz, bus.zero, bus.done}, 32'd1);
        check("post_dz_add_rem", bus.rem, 32'd0);
        @(posedge clk);
        #1;

        begin
            int done_seen;
            issue(ALU_DIVU, 32'd1000, 32'd3);
            repeat (9) begin
                @(posedge clk);
                #1;
            end
            check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
            rst_n = 1'b0;
            #1;
            $display("reset mid-divide -> busy=%0b done=%0b result=0x%08h", bus.busy, bus.done, bus.result);
            check("abort_flags", {26'd0, bus.busy, bus.done, bus.zero, bus.dz, bus.ovf, 1'b0}, 32'd0);
            check("abort_result", bus.result, 32'd0);
            check("abort_rem", bus.rem, 32'd0);
            done_seen = 0;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (bus.done || bus.busy) done_seen++;
            end
            rst_n = 1'b1;
            repeat (2) begin
                @(posedge clk);
                #1;
                if (bus.done || bus.busy) done_seen++;
            end
            check("abort_no_done", 32'(done_seen), 32'd0);
        end

        run_div(32'd9, 32'd3, 32'd3, 32'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
